calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
//
// Instruction sequencer for a small 8-bit calculator datapath. One
// instruction runs per accepted start: read two operands from an external
// register file, present them to an external combinational ALU, capture the
// result and write it back. A LOADK opcode bypasses the reads and the ALU
// and writes the keypad byte straight to the destination register.
//
// State sequence (every state except IDLE lasts one cycle):
//   ALU op : IDLE -> RD_A -> RD_B -> EXEC -> WB -> PCINC -> DONE -> IDLE
//   LOADK  : IDLE -> WB -> PCINC -> DONE -> IDLE
//
// Ports
//   clk      in   rising-edge clock
//   clr_n    in   asynchronous active-low reset
//   start    in   run one instruction (sampled in IDLE only)
//   op       in   [2:0] ALU opcode, 3'b111 = LOADK
//   src_a    in   [1:0] first operand register index
//   src_b    in   [1:0] second operand register index
//   dst      in   [1:0] destination register index
//   key_in   in   [7:0] keypad byte used by LOADK
//   rdata    in   [7:0] register-file read data (combinational from RA)
//   res_alu  in   [7:0] combinational ALU result of alu_a/alu_b/alu_op
//   RA       out  [1:0] register-file address, holds between accesses
//   rd       out  register-file read strobe
//   wr       out  register-file write strobe
//   wdata    out  [7:0] register-file write data, holds between writes
//   M        out  [1:0] PC mode: 2'b00 hold, 2'b01 increment
//   alu_a    out  [7:0] registered ALU operand A
//   alu_b    out  [7:0] registered ALU operand B
//   alu_op   out  [2:0] registered ALU opcode
//   busy     out  high whenever the FSM is not in IDLE
//   done     out  one-cycle completion pulse
//   op_cnt   out  [7:0] completed-instruction count, wraps modulo 256
// ---------------------------------------------------------------------------
module calc_sequencer (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [1:0] src_a,
  input  logic [1:0] src_b,
  input  logic [1:0] dst,
  input  logic [7:0] key_in,
  input  logic [7:0] rdata,
  input  logic [7:0] res_alu,
  output logic [1:0] RA,
  output logic       rd,
  output logic       wr,
  output logic [7:0] wdata,
  output logic [1:0] M,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic [7:0] op_cnt
);

  localparam logic [2:0] OP_LOADK = 3'b111;
  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_INC   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4,
    S_PCINC = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nxt;

  // Operand indices needed after the start cycle. src_a is consumed in the
  // start cycle itself (it goes straight into RA), so it needs no copy.
  logic [1:0] src_b_q;
  logic [1:0] dst_q;

  // Value to be written back. It only changes on the edge that enters WB,
  // so it doubles as the held write-data bus.
  logic [7:0] result;

  logic       is_loadk;

  assign is_loadk = (op == OP_LOADK);
  assign wdata    = result;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = is_loadk ? S_WB : S_RD_A;
        end
      end
      S_RD_A:  state_nxt = S_RD_B;
      S_RD_B:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_PCINC;
      S_PCINC: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Strobe decode. Purely a function of state, so the async reset forcing
  // IDLE also forces every strobe low without waiting for a clock.
  // -------------------------------------------------------------------------
  always_comb begin
    rd   = 1'b0;
    wr   = 1'b0;
    M    = PC_HOLD;
    done = 1'b0;
    busy = (state != S_IDLE);
    case (state)
      S_RD_A,
      S_RD_B:  rd   = 1'b1;
      S_WB:    wr   = 1'b1;
      S_PCINC: M    = PC_INC;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  //
  // RA is loaded on the edge that enters each access state, so the address
  // is already stable for the whole RD_A / RD_B / WB cycle and simply holds
  // in every other state.
  // -------------------------------------------------------------------------
  // NOTE: the datapath registers are reset too, because their reset value is
  // visible on the outputs; this is not a memory array, so clearing it is cheap.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      RA      <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      result  <= '0;
      op_cnt  <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            alu_op  <= op;
            src_b_q <= src_b;
            dst_q   <= dst;
            if (is_loadk) begin
              // Straight to write-back with the keypad byte.
              RA     <= dst;
              result <= key_in;
            end else begin
              RA     <= src_a;
            end
          end
        end
        S_RD_A: begin
          alu_a <= rdata;
          RA    <= src_b_q;
        end
        S_RD_B: begin
          alu_b <= rdata;
        end
        S_EXEC: begin
          result <= res_alu;
          RA     <= dst_q;
        end
        S_DONE: begin
          op_cnt <= op_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Read and write share the register-file address, so they must never
  // overlap.
  rd_wr_exclusive: assert property (@(posedge clk) disable iff (!clr_n) !(rd && wr));

endmodule
